// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter over a transmit/is_transmitting handshake,
// with fill level, overflow and missed-acknowledge reporting.
module uart_tx_feeder #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_lost,
  output logic                  busy,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]            state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            timer;
  logic                  do_pop;
  logic                  do_write;

  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count == '0);

  // A flush wins over both a same-cycle write and a pop decision.
  assign do_pop   = (state == IDLE) && !empty && !uart_is_transmitting && !flush;
  assign do_write = wr_en && !full && !flush;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      tx_lost       <= 1'b0;
      busy          <= 1'b0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= '0;
      state         <= IDLE;
      timer         <= '0;
    end else begin
      overflow      <= wr_en && full && !flush;
      uart_transmit <= do_pop;
      tx_lost       <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (do_pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({do_write, do_pop})
          2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
          2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
          default: count <= count;
        endcase
      end

      if (do_pop) uart_tx_byte <= mem[rd_ptr];

      case (state)
        IDLE: begin
          if (do_pop) begin
            state <= WAIT_BUSY;
            busy  <= 1'b1;
            timer <= '0;
          end
        end
        WAIT_BUSY: begin
          if (uart_is_transmitting) begin
            state <= WAIT_DONE;
          end else if (timer == 8'(START_TIMEOUT - 1)) begin
            // The popped byte is abandoned, not re-queued.
            tx_lost <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: vector table plus hand-written sequences,
// with a simple UART model and a byte-order scoreboard on the strobe.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_lost;
  logic       busy;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting;

  uart_tx_feeder #(.DEPTH_LOG2(4), .START_TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .flush                (flush),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .tx_lost              (tx_lost),
    .busy                 (busy),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  int          strobe_cnt = 0;
  int          viol = 0;
  logic        prev_tx = 1'b0;
  logic [7:0]  exp_q[$];

  // UART model: busy from the edge after it sees the strobe, for busy_len cycles.
  logic        ack_en = 1'b1;
  logic        hold_busy = 1'b0;
  int unsigned busy_len = 100;
  int unsigned remain = 0;

  always @(posedge clk) begin
    if (uart_transmit && ack_en) remain <= busy_len;
    else if (remain != 0)        remain <= remain - 1;
  end
  assign uart_is_transmitting = hold_busy || (remain != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (uart_transmit === 1'b1) begin
      strobe_cnt++;
      if (prev_tx) viol++;
      if (uart_is_transmitting) viol++;
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_byte_order", 32'(uart_tx_byte), 32'(exp_q.pop_front()));
    end
    prev_tx = (uart_transmit === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!(empty && !busy && !uart_is_transmitting) && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(n < bound), 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       hold;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_tx;
  } vec_t;

  localparam int NV = 20;
  vec_t vec[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int sc;

    // Burst to full with the UART held busy, overflow, then a pop racing a write at full.
    for (int i = 0; i < 16; i++)
      vec[i] = '{wr:1'b1, d:8'(i), fl:1'b0, hold:1'b1, e_count:5'(i + 1),
                 e_full:1'(i == 15), e_empty:1'b0, e_ovf:1'b0, e_tx:1'b0};
    vec[16] = '{wr:1'b1, d:8'hEE, fl:1'b0, hold:1'b1, e_count:5'd16,
                e_full:1'b1, e_empty:1'b0, e_ovf:1'b1, e_tx:1'b0};
    vec[17] = '{wr:1'b0, d:8'h00, fl:1'b0, hold:1'b1, e_count:5'd16,
                e_full:1'b1, e_empty:1'b0, e_ovf:1'b0, e_tx:1'b0};
    vec[18] = '{wr:1'b1, d:8'hEF, fl:1'b0, hold:1'b0, e_count:5'd15,
                e_full:1'b0, e_empty:1'b0, e_ovf:1'b1, e_tx:1'b1};
    vec[19] = '{wr:1'b0, d:8'h00, fl:1'b0, hold:1'b0, e_count:5'd15,
                e_full:1'b0, e_empty:1'b0, e_ovf:1'b0, e_tx:1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_lost", 32'(tx_lost), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_transmit", 32'(uart_transmit), 32'd0);
    chk("rst_tx_byte", 32'(uart_tx_byte), 32'h00);
    rst = 1'b0;
    tick();

    // Single byte latency and handshake.
    busy_len = 100;
    write_byte(8'hA5);
    chk("single_count_k", 32'(count), 32'd1);
    chk("single_tx_k", 32'(uart_transmit), 32'd0);
    tick();
    chk("single_tx_k1", 32'(uart_transmit), 32'd1);
    chk("single_byte_k1", 32'(uart_tx_byte), 32'hA5);
    chk("single_count_k1", 32'(count), 32'd0);
    chk("single_busy_k1", 32'(busy), 32'd1);
    tick();
    chk("single_tx_k2", 32'(uart_transmit), 32'd0);
    n = 0;
    while (uart_is_transmitting && n < 200) begin tick(); n++; end
    chk("single_uart_done", 32'(n < 200), 32'd1);
    chk("single_busy_hold", 32'(busy), 32'd1);
    tick();
    chk("single_busy_fall", 32'(busy), 32'd0);

    // Table-driven fill / overflow / pop-at-full rows.
    busy_len = 3;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < NV; i++) begin
      wr_en = vec[i].wr; wr_data = vec[i].d; flush = vec[i].fl; hold_busy = vec[i].hold;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vec[i].e_count));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vec[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vec[i].e_empty));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vec[i].e_ovf));
      chk($sformatf("vec%0d_transmit", i), 32'(uart_transmit), 32'(vec[i].e_tx));
    end
    wr_en = 1'b0; hold_busy = 1'b0;
    wait_idle(1000, "burst_drain");
    chk("burst_all_sent", 32'(exp_q.size()), 32'd0);
    chk("burst_strobes", 32'(strobe_cnt), 32'd17);

    // Move pointers to 14 so the next three entries wrap past index 15.
    hold_busy = 1'b1;
    for (int i = 0; i < 14; i++) write_byte(8'h80 + 8'(i));
    hold_busy = 1'b0;
    wait_idle(1000, "filler_drain");
    hold_busy = 1'b1;
    write_byte(8'h30); write_byte(8'h31); write_byte(8'h32);
    chk("wrap_count3", 32'(count), 32'd3);
    hold_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h33; exp_q.push_back(8'h33);
    tick();
    wr_en = 1'b0;
    chk("popwr_count", 32'(count), 32'd3);
    chk("popwr_transmit", 32'(uart_transmit), 32'd1);
    chk("popwr_byte", 32'(uart_tx_byte), 32'h30);
    wait_idle(1000, "wrap_drain");
    chk("wrap_all_sent", 32'(exp_q.size()), 32'd0);

    // Flush with a write while one byte is in flight.
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'h40 + 8'(i));
    busy_len = 20;
    hold_busy = 1'b0;
    tick();
    chk("flush_pre_tx", 32'(uart_transmit), 32'd1);
    chk("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_inflight_busy", 32'(busy), 32'd1);
    sc = strobe_cnt;
    wait_idle(200, "flush_inflight_done");
    tick(); tick();
    chk("flush_no_more_strobes", 32'(strobe_cnt), 32'(sc));

    // Missing acknowledge: tx_lost four cycles after each strobe.
    ack_en = 1'b0;
    write_byte(8'h50);
    write_byte(8'h51);
    chk("to_tx1", 32'(uart_transmit), 32'd1);
    chk("to_byte1", 32'(uart_tx_byte), 32'h50);
    n = 0;
    do begin tick(); n++; end while (!tx_lost && n < 10);
    chk("to_lost1_delay", 32'(n), 32'd4);
    tick();
    chk("to_lost1_pulse", 32'(tx_lost), 32'd0);
    chk("to_tx2", 32'(uart_transmit), 32'd1);
    chk("to_byte2", 32'(uart_tx_byte), 32'h51);
    n = 0;
    do begin tick(); n++; end while (!tx_lost && n < 10);
    chk("to_lost2_delay", 32'(n), 32'd4);
    chk("to_idle", 32'(busy), 32'd0);
    ack_en = 1'b1;
    tick();

    // Reset in the middle of a frame.
    busy_len = 3;
    hold_busy = 1'b1;
    write_byte(8'h60); write_byte(8'h61); write_byte(8'h62);
    hold_busy = 1'b0;
    tick();
    chk("midrst_tx", 32'(uart_transmit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_transmit", 32'(uart_transmit), 32'd0);
    chk("midrst_tx_byte", 32'(uart_tx_byte), 32'h00);
    sc = strobe_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_no_strobes", 32'(strobe_cnt), 32'(sc));

    chk("protocol_violations", 32'(viol), 32'd0);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and flow-control stage sitting directly upstream of the UART transmitter. Producers write bytes at full clock rate into an internal FIFO. The feeder hands bytes to the UART one at a time over the UART's `transmit`/`tx_byte`/`is_transmitting` handshake, so no byte is presented while a frame is in flight. It also reports fill level, overflow and handshake failures.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16); legal range 2..8.
- `START_TIMEOUT`, default 4: cycles to wait for `uart_is_transmitting` to rise after a transmit pulse; legal range 2..255.
- `clk` in, 1: clock.
- `rst` in, 1: reset; synchronous, active-high.
- `wr_en` in, 1: write strobe; `wr_data` is sampled on a rising edge where `wr_en`=1.
- `wr_data` in, 8: byte to enqueue.
- `flush` in, 1: discards every queued byte.
- `full` out, 1: count == 2^DEPTH_LOG2.
- `empty` out, 1: count == 0.
- `count` out, DEPTH_LOG2+1: number of queued bytes.
- `overflow` out, 1: one-cycle pulse when a write is dropped because the FIFO is full.
- `tx_lost` out, 1: one-cycle pulse when the UART fails to acknowledge within START_TIMEOUT.
- `busy` out, 1: state != IDLE.
- `uart_transmit` out, 1: one-cycle start strobe to the UART.
- `uart_tx_byte` out, 8: byte for the UART; held stable from the strobe until the next pop.
- `uart_is_transmitting` in, 1: UART busy flag.

## Operation
- FIFO: circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth, plus a separate count register. `full`/`empty` are derived from count.
- Write when not full: store the byte, advance the write pointer, count+1.
- Write when full: drop the byte; pointers and count unchanged; `overflow`=1 for the next cycle.
- Pop and write in the same cycle: both take effect; count unchanged. When full, a same-cycle pop does not rescue the write; it is still dropped and `overflow` pulses.
- `flush`: pointers and count go to 0. A write in the same cycle is discarded and does not pulse `overflow`. A byte already popped and in flight is not aborted.
- State machine:
  - IDLE: if count>0 and `uart_is_transmitting`=0, pop the head into `uart_tx_byte`, set `uart_transmit`=1, go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: `uart_transmit`=0. On `uart_is_transmitting`=1, go to WAIT_DONE. If the timer reaches START_TIMEOUT cycles first, pulse `tx_lost` and go to IDLE; the byte is not re-queued.
  - WAIT_DONE: on `uart_is_transmitting`=0, go to IDLE.
  - Unused state encodings go to IDLE.
- The timer counts cycles spent in WAIT_BUSY and is cleared on entry.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `tx_lost`=0, `busy`=0, `uart_transmit`=0, `uart_tx_byte`=8'h00; state IDLE; pointers 0.
- All outputs are registered.
- Latency:
  - `wr_en` sampled at edge k into an empty FIFO while IDLE and the UART is idle: the pop decision is made at edge k+1, and `uart_transmit`=1 with valid `uart_tx_byte` during cycle k+1..k+2.
  - `count` reads 1 during k..k+1 and 0 from k+1.
- `uart_transmit` is never high for more than one consecutive cycle.
- There are at least 2 cycles between strobes: strobe, WAIT_BUSY acknowledge, WAIT_DONE, IDLE.
- Back-to-back: the next strobe comes no earlier than one cycle after `uart_is_transmitting` is seen low in WAIT_DONE.
- `rst` mid-frame: all state returns to reset values at the next edge and queued bytes are lost. The UART's own frame is unaffected.

## Test plan
- Single byte: write 8'hA5 to an empty FIFO while the UART is idle.
  - `uart_transmit` pulses exactly 1 cycle, one edge after the write, with `uart_tx_byte`=8'hA5.
  - The model UART raises busy next cycle for 100 cycles; `busy` falls 1 cycle after it.
- Burst ordering: write 8'h00..8'h0F in consecutive cycles with DEPTH_LOG2=4.
  - `full` is 1 with `count`=16 after the last write, minus any byte already popped.
  - Bytes reach the UART in order 00..0F with no strobe while `uart_is_transmitting`=1.
- Overflow: hold the UART busy, write 17 bytes.
  - The 17th write pulses `overflow` once; `count`=16; contents unchanged.
- Simultaneous pop+write at count=3.
  - `count` stays 3; pointer wrap-around past index 15 preserves order.
- Flush: flush with `wr_en`=1 and 5 queued bytes.
  - `count`=0, `empty`=1, no `overflow`; the in-flight byte still completes.
- Timeout: model UART never raises busy.
  - `tx_lost` pulses exactly START_TIMEOUT=4 cycles after the strobe; the FSM returns to IDLE and sends the next byte.
